// File: rtl/audio_mix_dac.sv
// audio_mix_dac: time-multiplexed mixer of beeper, Specdrum and panned AY channels
// into 16-bit PCM, with a first-order sigma-delta 1-bit DAC per channel.
module audio_mix_dac (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        spk,
    input  logic        mic,
    input  logic        ear,
    input  logic [7:0]  specdrum,
    input  logic [7:0]  ay_a,
    input  logic [7:0]  ay_b,
    input  logic [7:0]  ay_c,
    input  logic [1:0]  stereo,
    input  logic        mute,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        valid,
    output logic        overrun,
    output logic        dac_l,
    output logic        dac_r
);
    localparam logic [2:0] IDLE = 3'd0, BEEP = 3'd1, SPEC = 3'd2, AYA = 3'd3,
                           AYB = 3'd4, AYC = 3'd5, DONE = 3'd6;
    logic [2:0]  state_q, state_d;
    logic        spk_q, mic_q, ear_q, mute_q;
    logic [7:0]  spec_q, a_q, b_q, c_q;
    logic [1:0]  st_q;
    logic [9:0]  acc_l_q, acc_r_q, ay_q;
    logic [9:0]  add_l, add_r, beep, a10, b10, c10;
    logic [15:0] left_q, right_q;
    logic        valid_q, overrun_q;
    logic [16:0] sd_l_q, sd_r_q;
    logic        mono, acb, start;
    assign start = ce && state_q == IDLE;
    assign mono  = st_q == 2'd2;
    assign acb   = st_q == 2'd1;
    assign a10   = {2'b0, a_q};
    assign b10   = {2'b0, b_q};
    assign c10   = {2'b0, c_q};
    assign beep  = (spk_q ? 10'd96 : 10'd0) + (mic_q ? 10'd32 : 10'd0) + (ear_q ? 10'd16 : 10'd0);
    assign state_d = state_q == IDLE ? (ce ? BEEP : IDLE) : state_q == DONE ? IDLE : state_q + 3'd1;
    // Mono defers the halving until the whole AY sum is known, so it lands in AYC.
    always_comb begin
        add_l = '0;
        add_r = '0;
        case (state_q)
            BEEP: begin add_l = beep; add_r = beep; end
            SPEC: begin add_l = {2'b0, spec_q}; add_r = {2'b0, spec_q}; end
            AYA:  add_l = mono ? '0 : a10;
            AYB: begin
                add_l = mono || acb ? '0 : b10 >> 1;
                add_r = mono ? '0 : acb ? b10 : b10 >> 1;
            end
            AYC: begin
                add_l = mono ? (ay_q + c10) >> 1 : acb ? c10 >> 1 : '0;
                add_r = mono ? (ay_q + c10) >> 1 : acb ? c10 >> 1 : c10;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            {spk_q, mic_q, ear_q, mute_q} <= '0;
            {spec_q, a_q, b_q, c_q} <= '0;
            st_q      <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            ay_q      <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            sd_l_q    <= '0;
            sd_r_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= state_q == DONE;
            if (ce && state_q != IDLE) overrun_q <= 1'b1;
            if (start) begin
                {spk_q, mic_q, ear_q, mute_q} <= {spk, mic, ear, mute};
                {spec_q, a_q, b_q, c_q} <= {specdrum, ay_a, ay_b, ay_c};
                st_q    <= stereo;
                acc_l_q <= '0;
                acc_r_q <= '0;
                ay_q    <= '0;
            end else begin
                acc_l_q <= acc_l_q + add_l;
                acc_r_q <= acc_r_q + add_r;
                if (state_q == AYA) ay_q <= a10;
                if (state_q == AYB) ay_q <= ay_q + b10;
            end
            if (state_q == DONE) begin
                left_q  <= mute_q ? '0 : {acc_l_q, 6'b0};
                right_q <= mute_q ? '0 : {acc_r_q, 6'b0};
            end
            sd_l_q <= {1'b0, sd_l_q[15:0]} + {1'b0, left_q};
            sd_r_q <= {1'b0, sd_r_q[15:0]} + {1'b0, right_q};
        end
    end
    assign left    = left_q;
    assign right   = right_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign dac_l   = sd_l_q[16];
    assign dac_r   = sd_r_q[16];
endmodule

// File: tb/tb_audio_mix_dac.sv
// tb_audio_mix_dac: table vectors, randomized passes against a behavioural mix
// model, and hand sequences for reset, overrun, mute and sigma-delta behaviour.
module tb_audio_mix_dac;
    logic        clock = 1'b0, reset = 1'b0, ce = 1'b0;
    logic        spk = 1'b0, mic = 1'b0, ear = 1'b0, mute = 1'b0;
    logic [7:0]  specdrum = '0, ay_a = '0, ay_b = '0, ay_c = '0;
    logic [1:0]  stereo = '0;
    logic [15:0] left, right;
    logic        valid, overrun, dac_l, dac_r;
    int checks = 0, failures = 0;

    typedef struct {
        logic spk, mic, ear;
        logic [7:0] sd, a, b, c;
        logic [1:0] st;
        logic mu;
        logic [15:0] el, er;
    } vec_t;
    vec_t tbl[8];

    audio_mix_dac dut (
        .clock(clock), .reset(reset), .ce(ce), .spk(spk), .mic(mic), .ear(ear),
        .specdrum(specdrum), .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c),
        .stereo(stereo), .mute(mute), .left(left), .right(right),
        .valid(valid), .overrun(overrun), .dac_l(dac_l), .dac_r(dac_r)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, m, e, input logic [7:0] sd, a, b, c,
                                input logic [1:0] st, input logic mu,
                                input logic [15:0] el, er);
        vec_t v;
        v.spk = s; v.mic = m; v.ear = e; v.sd = sd; v.a = a; v.b = b; v.c = c;
        v.st = st; v.mu = mu; v.el = el; v.er = er;
        return v;
    endfunction

    // Behavioural reference: whole-pass arithmetic straight from the mixing rules.
    function automatic logic [15:0] mix(input vec_t v, input bit want_right);
        int base, l, r;
        base = 96 * v.spk + 32 * v.mic + 16 * v.ear + int'(v.sd);
        if (v.st == 2) begin
            l = base + (int'(v.a) + int'(v.b) + int'(v.c)) / 2;
            r = l;
        end else if (v.st == 1) begin
            l = base + int'(v.a) + int'(v.c) / 2;
            r = base + int'(v.b) + int'(v.c) / 2;
        end else begin
            l = base + int'(v.a) + int'(v.b) / 2;
            r = base + int'(v.c) + int'(v.b) / 2;
        end
        return v.mu ? 16'h0 : 16'((want_right ? r : l) * 64);
    endfunction

    task automatic drive(input vec_t v);
        {spk, mic, ear, mute} = {v.spk, v.mic, v.ear, v.mu};
        {specdrum, ay_a, ay_b, ay_c} = {v.sd, v.a, v.b, v.c};
        stereo = v.st;
    endtask

    task automatic scramble();
        {spk, mic, ear, mute} = 4'($urandom);
        {specdrum, ay_a, ay_b, ay_c} = $urandom;
        stereo = 2'($urandom);
    endtask

    // Called just after a rising edge; ce is sampled at the next edge (N).
    task automatic run_pass(input string name, input vec_t v, input bit scr);
        int nv = 0, vat = 0;
        drive(v);
        ce = 1'b1;
        @(posedge clock); #1;
        ce = 1'b0;
        if (scr) scramble();
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            if (valid) begin nv++; vat = k; end
        end
        check({name, "_valid_count"}, nv, 1);
        check({name, "_valid_edge"}, vat, 6);
        check({name, "_left"}, left, v.el);
        check({name, "_right"}, right, v.er);
    endtask

    initial begin
        vec_t v;
        int nv, ones_l, ones_r;
        logic prev;
        tbl[0] = mk(0, 0, 0, 8'h80, 8'h00, 8'h00, 8'h00, 2'd0, 0, 16'h2000, 16'h2000);
        tbl[1] = mk(1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, 0, 16'hC340, 16'hC340);
        tbl[2] = mk(1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd2, 0, 16'hC340, 16'hC340);
        tbl[3] = mk(1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd3, 0, 16'hC340, 16'hC340);
        tbl[4] = mk(0, 0, 0, 8'h00, 8'h40, 8'h20, 8'h00, 2'd0, 0, 16'h1400, 16'h0400);
        tbl[5] = mk(0, 0, 0, 8'h00, 8'h40, 8'h20, 8'h00, 2'd1, 0, 16'h1000, 16'h0800);
        tbl[6] = mk(1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, 1, 16'h0000, 16'h0000);
        tbl[7] = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 16'h1800, 16'h1800);

        repeat (3) @(posedge clock);
        #1;
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_dac", {dac_l, dac_r}, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 8; i++) run_pass($sformatf("tbl%0d", i), tbl[i], 1'b1);

        for (int i = 0; i < 40; i++) begin
            v = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, ($urandom_range(0, 7) == 0), 0, 0);
            v.el = mix(v, 0);
            v.er = mix(v, 1);
            run_pass($sformatf("rnd%0d", i), v, 1'b1);
        end
        check("no_overrun_yet", overrun, 0);

        // ce landing in the DONE cycle is an overrun, not a queued pass.
        drive(tbl[0]);
        ce = 1'b1;
        @(posedge clock); #1;
        ce = 1'b0;
        nv = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 6) ce = 1'b1;
            @(posedge clock); #1;
            ce = 1'b0;
            if (valid) nv++;
        end
        check("done_ce_valids", nv, 1);
        check("done_ce_overrun", overrun, 1);

        // Reset mid-pass.
        drive(tbl[1]);
        ce = 1'b1;
        @(posedge clock); #1;
        ce = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_left", left, 0);
        check("midrst_right", right, 0);
        check("midrst_valid", valid, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_dac", {dac_l, dac_r}, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            if (valid) nv++;
        end
        check("midrst_no_valid", nv, 0);
        run_pass("after_rst", tbl[4], 1'b0);

        // ce again at N+3 while busy.
        drive(tbl[5]);
        ce = 1'b1;
        @(posedge clock); #1;
        ce = 1'b0;
        nv = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) begin ay_a = 8'h11; ce = 1'b1; end
            @(posedge clock); #1;
            ce = 1'b0;
            if (valid) nv++;
        end
        check("busy_ce_valids", nv, 1);
        check("busy_ce_left", left, 16'h1000);
        check("busy_ce_overrun", overrun, 1);
        run_pass("mute", mk(0, 0, 0, 8'h80, 8'h40, 8'h20, 8'h10, 2'd0, 1, 0, 0), 1'b0);
        check("overrun_sticky", overrun, 1);

        // Sigma-delta at half scale: strict alternation.
        run_pass("sd_half", mk(1, 1, 1, 8'hFF, 8'd113, 0, 0, 2'd0, 0, 16'h8000, 16'h63C0), 1'b0);
        prev = dac_l;
        for (int k = 0; k < 16; k++) begin
            @(posedge clock); #1;
            check("sd_half_alt", dac_l, !prev);
            prev = dac_l;
        end

        run_pass("sd_zero", mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0), 1'b0);
        ones_l = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clock); #1;
            ones_l += dac_l;
        end
        check("sd_zero_ones", ones_l, 0);

        run_pass("sd_quarter", mk(0, 0, 1, 8'd240, 0, 0, 0, 2'd0, 0, 16'h4000, 16'h4000), 1'b0);
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < 1024; k++) begin
            @(posedge clock); #1;
            ones_l += dac_l;
            ones_r += dac_r;
        end
        check("sd_quarter_l", ones_l, 256);
        check("sd_quarter_r", ones_r, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
